// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift request arbiter and its base-3 datapath.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] TRIT0 = 2'b00;
    localparam logic [1:0] TRIT1 = 2'b01;
    localparam logic [1:0] TRIT2 = 2'b10;

    // Largest amount representable with three trits (2*9 + 2*3 + 2).
    localparam logic [4:0] MAX_ENC_AMT = 5'd26;
    localparam int unsigned CONV_CYCLES = 3;

endpackage

// File: rtl/base3_digit.sv
// One base-3 conversion step: splits a residual into its lowest trit and the remaining quotient.
module base3_digit
    import shift_ctrl_pkg::*;
(
    input  logic [4:0] resid,
    output logic [1:0] trit,
    output logic [4:0] resid_next
);

    logic [4:0] rem;

    always_comb begin
        rem        = resid % 5'd3;
        resid_next = resid / 5'd3;
        case (rem[1:0])
            2'd1:    trit = TRIT1;
            2'd2:    trit = TRIT2;
            default: trit = TRIT0;
        endcase
    end

endmodule

// File: rtl/shifter_sll.sv
// 16-bit logical left shifter whose amount is given as three trits (weights 1, 3, 9).
module shifter_sll
    import shift_ctrl_pkg::*;
(
    input  logic [15:0] a,
    input  logic [5:0]  b,
    output logic [15:0] y
);

    function automatic logic [15:0] stage(input logic [15:0] v, input logic [1:0] t,
                                          input int unsigned w);
        case (t)
            TRIT1:   return v << w;
            TRIT2:   return v << (2 * w);
            default: return v;
        endcase
    endfunction

    always_comb begin
        y = stage(stage(stage(a, b[1:0], 1), b[3:2], 3), b[5:4], 9);
    end

endmodule

// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin front end that converts binary shift amounts to base 3,
// drives the shared shifter and returns the tagged result over a valid/ready port.
module shift_req_arbiter
    import shift_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][15:0] req_data,
    input  logic [NREQ-1:0][4:0]  req_amt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_data,
    output logic                  resp_id,
    output logic                  resp_sat,
    output logic                  busy
);

    localparam logic [1:0] K_LAST = 2'(CONV_CYCLES - 1);

    state_e      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [15:0] data_q, data_d;
    logic [4:0]  resid_q, resid_d;
    logic [5:0]  base3_q, base3_d;
    logic [1:0]  k_q, k_d;
    logic        id_q, id_d;
    logic        sat_q, sat_d;
    logic [15:0] resp_data_q, resp_data_d;

    logic [NREQ-1:0] grant;
    logic            g_id;
    logic [1:0]      trit;
    logic [4:0]      resid_next;
    logic [15:0]     shift_y;

    base3_digit u_digit (
        .resid      (resid_q),
        .trit       (trit),
        .resid_next (resid_next)
    );

    shifter_sll u_shifter (
        .a (data_q),
        .b (base3_q),
        .y (shift_y)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant       = (req_valid == 2'b11) ? (rr_ptr_q ? 2'b10 : 2'b01) : req_valid;
        g_id        = grant[1];
        req_ready   = (state_q == IDLE) ? grant : '0;

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        resid_d     = resid_q;
        base3_d     = base3_q;
        k_d         = k_q;
        id_d        = id_q;
        sat_d       = sat_q;
        resp_data_d = resp_data_q;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    data_d   = req_data[g_id];
                    resid_d  = req_amt[g_id];
                    id_d     = g_id;
                    // Pointer moves to the requester that was not just served.
                    rr_ptr_d = ~g_id;
                    k_d      = '0;
                    base3_d  = '0;
                    sat_d    = req_amt[g_id] > MAX_ENC_AMT;
                    state_d  = (req_amt[g_id] > MAX_ENC_AMT) ? SHIFT : CONV;
                end
            end
            CONV: begin
                case (k_q)
                    2'd0:    base3_d[1:0] = trit;
                    2'd1:    base3_d[3:2] = trit;
                    default: base3_d[5:4] = trit;
                endcase
                resid_d = resid_next;
                k_d     = k_q + 2'd1;
                if (k_q == K_LAST) state_d = SHIFT;
            end
            SHIFT: begin
                resp_data_d = sat_q ? 16'h0000 : shift_y;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, because their values are visible on the outputs.
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            data_q      <= '0;
            resid_q     <= '0;
            base3_q     <= '0;
            k_q         <= '0;
            id_q        <= 1'b0;
            sat_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            data_q      <= data_d;
            resid_q     <= resid_d;
            base3_q     <= base3_d;
            k_q         <= k_d;
            id_q        <= id_d;
            sat_q       <= sat_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_data  = resp_data_q;
    assign resp_id    = id_q;
    assign resp_sat   = sat_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Randomized and directed bench for shift_req_arbiter against an arithmetic reference model.
module tb_shift_req_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][15:0] req_data;
    logic [1:0][4:0] req_amt;
    logic            resp_valid;
    logic            resp_ready;
    logic [15:0]     resp_data;
    logic            resp_id;
    logic            resp_sat;
    logic            busy;

    int   n_checks = 0;
    int   n_errors = 0;
    logic rr_m;

    shift_req_arbiter #(.NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_sat   (resp_sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && req_ready == 2'b11) begin
            n_errors++;
            $display("FAIL ready_two_hot: got 2'b11 at %0t", $time);
        end
    end

    // Shift amount as an integer: results past bit 15 fall off, unencodable amounts give 0.
    function automatic logic [15:0] model_result(input logic [15:0] d, input int amt);
        if (amt > 26 || amt >= 16) return 16'h0000;
        return d << amt;
    endfunction

    function automatic logic [5:0] model_b3(input int amt);
        if (amt > 26) return 6'd0;
        return 6'(((amt / 9) % 3) * 16 + ((amt / 3) % 3) * 4 + (amt % 3));
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input logic [1:0] vmask, input logic [15:0] d0, input logic [15:0] d1,
                          input int a0, input int a1, input int stall);
        int          g;
        int          n;
        int          amt;
        logic [15:0] ed;
        logic [5:0]  eb;
        logic        es;
        req_valid  = vmask;
        req_data[0] = d0;
        req_data[1] = d1;
        req_amt[0] = 5'(a0);
        req_amt[1] = 5'(a1);
        resp_ready = 1'b0;
        g   = (vmask == 2'b11) ? int'(rr_m) : (vmask[1] ? 1 : 0);
        amt = g ? a1 : a0;
        es  = amt > 26;
        ed  = model_result(g ? d1 : d0, amt);
        eb  = model_b3(amt);
        #1;
        check("grant", 32'(req_ready), 32'(2'b01 << g));
        step;
        rr_m = (g == 0);
        req_valid = 2'b00;
        req_data[0] = 16'($urandom);
        req_data[1] = 16'($urandom);
        req_amt[0] = 5'($urandom);
        req_amt[1] = 5'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 1;
        while (!resp_valid && n < 12) begin
            step;
            n++;
        end
        check("latency", n, es ? 2 : 5);
        check("resp_data", 32'(resp_data), 32'(ed));
        check("resp_id", 32'(resp_id), g);
        check("resp_sat", 32'(resp_sat), 32'(es));
        check("base3_b", 32'(dut.base3_q), 32'(eb));
        req_valid = vmask;
        for (int i = 0; i < stall; i++) begin
            step;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", 32'(resp_data), 32'(ed));
            check("hold_id", 32'(resp_id), g);
            check("hold_no_accept", 32'(req_ready), 32'd0);
            check("hold_rr_ptr", 32'(dut.rr_ptr_q), 32'(rr_m));
        end
        resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        check("resp_released", 32'(resp_valid), 32'd0);
        check("idle_after_resp", 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data   = '0;
        req_amt    = '0;
        resp_ready = 1'b0;
        rr_m       = 1'b0;
        step;
        step;
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_sat", 32'(resp_sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        check("rst_base3", 32'(dut.base3_q), 32'd0);

        do_job(2'b01, 16'h0001, 16'h1234, 5, 3, 0);
        do_job(2'b10, 16'h5555, 16'h00FF, 1, 9, 0);
        do_job(2'b01, 16'hABCD, 16'h0000, 26, 0, 1);
        do_job(2'b10, 16'hFFFF, 16'hFFFF, 0, 27, 0);
        for (int j = 0; j < 4; j++)
            do_job(2'b11, 16'(16'h0100 + j), 16'(16'h0200 + j), j + 1, j + 2, 0);
        do_job(2'b11, 16'h0F0F, 16'hF0F0, 4, 7, 3);
        do_job(2'b10, 16'h1111, 16'h0003, 0, 15, 0);

        for (int j = 0; j < 24; j++)
            do_job(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 2)));

        req_valid   = 2'b10;
        req_data[1] = 16'h0001;
        req_amt[1]  = 5'd5;
        step;
        req_valid = 2'b00;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        rr_m = 1'b0;
        check("mid_rst_idle", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        check("mid_rst_data", 32'(resp_data), 32'd0);
        check("mid_rst_base3", 32'(dut.base3_q), 32'd0);
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (resp_valid) seen++;
        end
        resp_ready = 1'b0;
        check("dropped_job_silent", seen, 0);

        do_job(2'b11, 16'h0007, 16'h0009, 2, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
